// File: rtl/usb_fifo_bridge_if.sv
// USB/FIFO handshake and data bundle for usb_fifo_bridge.
// master = bridge side, slave = ezusb_io / dram_fifo side.
interface usb_fifo_bridge_if #(
    parameter int USB_WIDTH  = 16,
    parameter int FIFO_WIDTH = 128
);
    logic [USB_WIDTH-1:0]  usb_data_out;
    logic                  usb_out_valid;
    logic                  usb_out_ready;
    logic [USB_WIDTH-1:0]  usb_data_in;
    logic                  usb_in_valid;
    logic                  usb_in_ready;
    logic [FIFO_WIDTH-1:0] fifo_data_in;
    logic                  fifo_wr_en;
    logic                  fifo_wr_full;
    logic                  fifo_wr_err;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  fifo_rd_empty;
    logic                  fifo_rd_err;

    modport master (
        input  usb_data_out, usb_out_valid, usb_in_ready,
        input  fifo_wr_full, fifo_wr_err,
        input  fifo_data_out, fifo_rd_empty, fifo_rd_err,
        output usb_out_ready, usb_data_in, usb_in_valid,
        output fifo_data_in, fifo_wr_en, fifo_rd_en
    );

    modport slave (
        output usb_data_out, usb_out_valid, usb_in_ready,
        output fifo_wr_full, fifo_wr_err,
        output fifo_data_out, fifo_rd_empty, fifo_rd_err,
        input  usb_out_ready, usb_data_in, usb_in_valid,
        input  fifo_data_in, fifo_wr_en, fifo_rd_en
    );
endinterface

// File: rtl/usb_fifo_bridge.sv
// USB <-> DRAM FIFO width-conversion bridge (pack / unpack).
// Define USB_FIFO_BRIDGE_FLUSH_EN for timed/requested partial flush.
module usb_fifo_bridge #(
    parameter int unsigned          USB_WIDTH    = 16,
    parameter int unsigned          FIFO_WIDTH   = 128,
    parameter int unsigned          FLUSH_CYCLES = 1024,
    parameter logic [USB_WIDTH-1:0] PAD_WORD     = '0
) (
    input  logic              ifclk,
    input  logic              reset,
    usb_fifo_bridge_if.master bus,
    input  logic              flush_req,
    input  logic              clear_err,
    output logic [1:0]        err_sticky,
    output logic [31:0]       wr_words,
    output logic [31:0]       rd_words,
    output logic [15:0]       flush_count,
    output logic [3:0]        pack_level
);
    localparam int unsigned R  = FIFO_WIDTH / USB_WIDTH;
    localparam int unsigned KW = $clog2(R);
    localparam logic [KW-1:0] K_LAST = KW'(R - 1);
    localparam logic [KW:0]   M_FULL = (KW + 1)'(R);
    localparam logic [KW:0]   M_ONE  = (KW + 1)'(1);

    logic                  rdy_q;
    logic [KW-1:0]         k;
    logic [FIFO_WIDTH-1:0] pack_buf;
    logic [FIFO_WIDTH-1:0] pack_next;
    logic [FIFO_WIDTH-1:0] pad_next;
    logic [FIFO_WIDTH-1:0] pend_data;
    logic                  pend_valid;
    logic [FIFO_WIDTH-1:0] ub;
    logic [KW:0]           m;
    logic                  accept;
    logic                  complete;
    logic                  flush_fire;
    logic                  load;
    logic                  in_fire;

    // rdy_q keeps every handshake output low until the first edge after reset
    assign bus.usb_out_ready = rdy_q && (!pend_valid || !bus.fifo_wr_full);
    assign accept   = bus.usb_out_valid && bus.usb_out_ready;
    assign complete = accept && (k == K_LAST);
    assign load     = complete || flush_fire;

    assign bus.fifo_wr_en   = pend_valid && !bus.fifo_wr_full;
    assign bus.fifo_data_in = pend_data;
    assign pack_level       = 4'(k);

    always_comb begin
        pack_next = pack_buf;
        pack_next[k*USB_WIDTH +: USB_WIDTH] = bus.usb_data_out;
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            k          <= '0;
            pack_buf   <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (complete) begin
                pend_data <= pack_next;
                k         <= '0;
            end else if (accept) begin
                pack_buf <= pack_next;
                k        <= k + 1'b1;
            end else if (flush_fire) begin
                pend_data <= pad_next;
                k         <= '0;
            end
            if (load)
                pend_valid <= 1'b1;
            else if (bus.fifo_wr_en)
                pend_valid <= 1'b0;
        end
    end

`ifdef USB_FIFO_BRIDGE_FLUSH_EN
    localparam logic [15:0] FC = 16'(FLUSH_CYCLES);
    logic [15:0] idle_cnt;
    logic [15:0] flush_cnt;
    logic        flush_ok;

    always_comb begin
        pad_next = pack_buf;
        for (int j = 0; j < int'(R); j++)
            if (j >= int'(k))
                pad_next[j*USB_WIDTH +: USB_WIDTH] = PAD_WORD;
    end

    // flush yields to acceptance and to a stuck pending word
    assign flush_ok = (k != '0) && !accept &&
                      (!pend_valid || !bus.fifo_wr_full);
    assign flush_fire = flush_ok && (flush_req || idle_cnt >= FC);
    assign flush_count = flush_cnt;

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            idle_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept || k == '0 || flush_fire)
                idle_cnt <= '0;
            else if (idle_cnt < FC)
                idle_cnt <= idle_cnt + 16'd1;
            if (flush_fire && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    logic flush_unused;
    assign pad_next     = pack_buf;
    assign flush_fire   = 1'b0;
    assign flush_count  = '0;
    assign flush_unused = ^{flush_req, PAD_WORD, 32'(FLUSH_CYCLES), pad_next};
`endif

    assign in_fire          = bus.usb_in_valid && bus.usb_in_ready;
    assign bus.usb_in_valid = (m != '0);
    assign bus.usb_data_in  = ub[USB_WIDTH-1:0];
    // refill on the last handshake so FIFO words stream gap-free
    assign bus.fifo_rd_en = rdy_q && !bus.fifo_rd_empty &&
                            (m == '0 || (m == M_ONE && bus.usb_in_ready));

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            ub <= '0;
            m  <= '0;
        end else if (bus.fifo_rd_en) begin
            ub <= bus.fifo_data_out;
            m  <= M_FULL;
        end else if (in_fire) begin
            ub <= ub >> USB_WIDTH;
            m  <= m - M_ONE;
        end
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            err_sticky <= '0;
            wr_words   <= '0;
            rd_words   <= '0;
        end else begin
            err_sticky <= (err_sticky & {2{!clear_err}}) |
                          {bus.fifo_rd_err, bus.fifo_wr_err};
            if (bus.fifo_wr_en)
                wr_words <= wr_words + 32'd1;
            if (bus.fifo_rd_en)
                rd_words <= rd_words + 32'd1;
        end
    end
endmodule

// File: tb/tb_usb_fifo_bridge.sv
// Scoreboard bench for usb_fifo_bridge (16 -> 128 bit, R = 8).
`timescale 1ns/1ps
module tb_usb_fifo_bridge;
    localparam int UW = 16;
    localparam int FW = 128;
    localparam logic [15:0] PAD = 16'hA5A5;

    logic        ifclk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_req = 1'b0;
    logic        clear_err = 1'b0;
    logic [1:0]  err_sticky;
    logic [31:0] wr_words;
    logic [31:0] rd_words;
    logic [15:0] flush_count;
    logic [3:0]  pack_level;

    usb_fifo_bridge_if #(.USB_WIDTH(UW), .FIFO_WIDTH(FW)) bus();

    usb_fifo_bridge #(
        .USB_WIDTH(UW), .FIFO_WIDTH(FW),
        .FLUSH_CYCLES(8), .PAD_WORD(PAD)
    ) dut (
        .ifclk(ifclk), .reset(reset), .bus(bus.master),
        .flush_req(flush_req), .clear_err(clear_err),
        .err_sticky(err_sticky), .wr_words(wr_words),
        .rd_words(rd_words), .flush_count(flush_count),
        .pack_level(pack_level)
    );

    always #5 ifclk = ~ifclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_cnt = 0;
    int wr_seen = 0;
    int first_wr_cyc = -1;

    logic [FW-1:0] exp_wr[$];
    logic [UW-1:0] exp_rd[$];
    logic [FW-1:0] rd_fifo[$];

    always @(posedge ifclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FW-1:0] act,
                         input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack8(input logic [15:0] base);
        logic [FW-1:0] r;
        for (int j = 0; j < 8; j++)
            r[j*16 +: 16] = base + 16'(j);
        return r;
    endfunction

    function void refresh();
        bus.fifo_rd_empty = (rd_fifo.size() == 0);
        bus.fifo_data_out = (rd_fifo.size() != 0) ? rd_fifo[0] : '0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge ifclk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        bus.usb_data_out = d;
        bus.usb_out_valid = 1'b1;
        while (!ok && n < 64) begin
            @(negedge ifclk);
            if (bus.usb_out_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted", d);
            @(posedge ifclk);
            #1;
        end else begin
            @(posedge ifclk);
            #1;
            acc_cyc = cyc;
            acc_cnt++;
        end
        bus.usb_out_valid = 1'b0;
    endtask

    always @(negedge ifclk) begin
        if (!reset && bus.fifo_wr_en) begin
            if (wr_seen == 0) first_wr_cyc = cyc;
            wr_seen++;
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got %0h expected none",
                         bus.fifo_data_in);
            end else begin
                check("fifo_wr_data", bus.fifo_data_in, exp_wr.pop_front());
            end
        end
        if (!reset && bus.usb_in_valid && bus.usb_in_ready) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %0h expected none",
                         bus.usb_data_in);
            end else begin
                check("usb_rd_data", FW'(bus.usb_data_in),
                      FW'(exp_rd.pop_front()));
            end
        end
    end

    initial begin : fifo_model
        logic take;
        forever begin
            @(negedge ifclk);
            take = bus.fifo_rd_en;
            @(posedge ifclk);
            #1;
            if (take && rd_fifo.size() != 0) void'(rd_fifo.pop_front());
            refresh();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] rw [3];
        int gaps;
        int acc8;
        bus.usb_data_out  = '0;
        bus.usb_out_valid = 1'b0;
        bus.usb_in_ready  = 1'b1;
        bus.fifo_wr_full  = 1'b0;
        bus.fifo_wr_err   = 1'b0;
        bus.fifo_rd_err   = 1'b0;
        refresh();

        repeat (3) @(posedge ifclk);
        @(negedge ifclk);
        check("rst_out_ready", bus.usb_out_ready, 0);
        check("rst_in_valid", bus.usb_in_valid, 0);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_data_in", bus.usb_data_in, 0);
        check("rst_fifo_data", bus.fifo_data_in, 0);
        check("rst_err", err_sticky, 0);
        check("rst_wr_words", wr_words, 0);
        check("rst_rd_words", rd_words, 0);
        check("rst_flush_cnt", flush_count, 0);
        check("rst_pack_level", pack_level, 0);
        tick(1);
        reset = 1'b0;
        @(negedge ifclk);
        check("ready_release", bus.usb_out_ready, 0);
        @(negedge ifclk);
        check("ready_after", bus.usb_out_ready, 1);
        tick(1);

        exp_wr.push_back(128'h0008_0007_0006_0005_0004_0003_0002_0001);
        exp_wr.push_back(128'h0010_000F_000E_000D_000C_000B_000A_0009);
        acc8 = 0;
        for (int i = 1; i <= 16; i++) begin
            send(16'(i));
            if (i == 8) acc8 = acc_cyc;
        end
        tick(3);
        check("wr_latency", 128'(first_wr_cyc), 128'(acc8));
        check("wr_words_2", wr_words, 2);
        check("pack_level_0", pack_level, 0);

        exp_wr.push_back(pack8(16'h0101));
        exp_wr.push_back(pack8(16'h0109));
        exp_wr.push_back(pack8(16'h0111));
        bus.fifo_wr_full = 1'b1;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) send(16'h0101 + 16'(i));
            end
            begin
                repeat (20) @(posedge ifclk);
                @(negedge ifclk);
                check("bp_ready_low", bus.usb_out_ready, 0);
                check("bp_accepted", 128'(acc_cnt), 8);
                check("bp_no_write", wr_words, 2);
                @(posedge ifclk);
                #1;
                bus.fifo_wr_full = 1'b0;
            end
        join
        tick(4);
        check("bp_wr_words", wr_words, 5);
        check("bp_accept_all", 128'(acc_cnt), 24);

        rw[0] = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
        rw[1] = 128'h2007_2006_2005_2004_2003_2002_2001_2000;
        rw[2] = 128'h3007_3006_3005_3004_3003_3002_3001_3000;
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 8; j++) exp_rd.push_back(rw[w][j*16 +: 16]);
            rd_fifo.push_back(rw[w]);
        end
        refresh();
        @(negedge ifclk);
        check("rd_latency", bus.fifo_rd_en, 1);
        gaps = 0;
        repeat (24) begin
            @(negedge ifclk);
            if (!bus.usb_in_valid) gaps++;
        end
        check("rd_no_gaps", 128'(gaps), 0);
        @(negedge ifclk);
        check("rd_drained", bus.usb_in_valid, 0);
        check("rd_words_3", rd_words, 3);
        tick(1);

`ifdef USB_FIFO_BRIDGE_FLUSH_EN
        exp_wr.push_back(128'hA5A5_A5A5_A5A5_A5A5_A5A5_0A03_0A02_0A01);
        for (int i = 1; i <= 3; i++) send(16'h0A00 + 16'(i));
        tick(20);
        check("flush_count_1", flush_count, 1);
        check("flush_pack_0", pack_level, 0);
        check("flush_wr_words", wr_words, 6);
`else
        for (int i = 1; i <= 3; i++) send(16'h0A00 + 16'(i));
        tick(20);
        check("noflush_pack_3", pack_level, 3);
        check("noflush_wr_words", wr_words, 5);
        check("noflush_count", flush_count, 0);
        exp_wr.push_back(pack8(16'h0A01));
        for (int i = 4; i <= 8; i++) send(16'h0A00 + 16'(i));
        tick(3);
        check("noflush_complete", wr_words, 6);
`endif

        bus.fifo_rd_err = 1'b1;
        tick(1);
        bus.fifo_rd_err = 1'b0;
        @(negedge ifclk);
        check("err_rd_set", err_sticky, 2'b10);
        tick(3);
        @(negedge ifclk);
        check("err_rd_hold", err_sticky, 2'b10);
        tick(1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        @(negedge ifclk);
        check("err_cleared", err_sticky, 2'b00);
        tick(1);
        clear_err = 1'b1;
        bus.fifo_wr_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        bus.fifo_wr_err = 1'b0;
        @(negedge ifclk);
        check("err_set_wins", err_sticky, 2'b01);
        tick(1);

        for (int i = 1; i <= 5; i++) send(16'h0B00 + 16'(i));
        @(negedge ifclk);
        check("mid_pack_5", pack_level, 5);
        tick(1);
        reset = 1'b1;
        @(negedge ifclk);
        check("mid_rst_pack", pack_level, 0);
        check("mid_rst_ready", bus.usb_out_ready, 0);
        check("mid_rst_wr_en", bus.fifo_wr_en, 0);
        check("mid_rst_in_valid", bus.usb_in_valid, 0);
        check("mid_rst_err", err_sticky, 0);
        check("mid_rst_wr_words", wr_words, 0);
        check("mid_rst_rd_words", rd_words, 0);
        check("mid_rst_fifo_data", bus.fifo_data_in, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        exp_wr.push_back(pack8(16'h0C01));
        for (int i = 0; i < 8; i++) send(16'h0C01 + 16'(i));
        tick(3);
        check("post_rst_wr", wr_words, 1);
        check("post_rst_pack", pack_level, 0);

        for (int i = 0; i < 50 && (exp_wr.size() != 0 || exp_rd.size() != 0); i++)
            tick(1);
        check("exp_wr_empty", 128'(exp_wr.size()), 0);
        check("exp_rd_empty", 128'(exp_rd.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
